ps2_keycode_rx: RTL

- Receives PS/2 keyboard frames (scan code set 2) and decodes make/break sequences into a held-key level output.
- The output is an 8-bit USB-HID keycode: the value of the key currently held, or 0 when no key is held.
- Drives the `keycode` input of the tile game logic and so replaces the USB keyboard path.
- Runs entirely in the system `Clk` domain; the PS/2 pins are oversampled.

---
 rtl/ps2_keycode_rx.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 keyboard receiver: decodes make/break codes into a held-key USB-HID keycode.
// Define PS2_MULTIKEY_EN to build a two-deep held-key stack so releasing the newest key restores the older one.
module ps2_keycode_rx #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          sample_ev, clk_s, dat_s;

    state_t        state_q, state_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          byte_done_q, byte_done_d;
    logic [7:0]    byte_q;
    logic          frame_err_q, frame_err_d;

    logic          ext_q, ext_d, brk_q, brk_d;
    logic [7:0]    keycode_q, keycode_d, hid_code;
    logic          key_valid_q, key_valid_d;
`ifdef PS2_MULTIKEY_EN
    logic [7:0]    older_q, older_d;
`endif

    function automatic logic [7:0] hid_map(input logic [7:0] sc);
        case (sc)
            8'h23:   hid_map = 8'h07;
            8'h2B:   hid_map = 8'h09;
            8'h29:   hid_map = 8'h2C;
            8'h3B:   hid_map = 8'h0D;
            8'h42:   hid_map = 8'h0E;
            8'h5A:   hid_map = 8'h28;
            8'h76:   hid_map = 8'h29;
            default: hid_map = 8'h00;
        endcase
    endfunction

    // Synchronizers and clock glitch filter; a sample event is the filtered 1->0 transition.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], PS2_CLK};
        dat_sync_d = {dat_sync_q[0], PS2_DAT};
        clk_s      = clk_sync_q[1];
        dat_s      = dat_sync_q[1];
        filt_d     = filt_q;
        fcnt_d     = '0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1))
                filt_d = clk_s;
            else
                fcnt_d = fcnt_q + 1'b1;
        end
        sample_ev = filt_q & ~filt_d;
    end

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tcnt_d      = tcnt_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;
        if (sample_ev) begin
            tcnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (!dat_s) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (dat_s && (^{shift_q, par_q}))
                        byte_done_d = 1'b1;
                    else
                        frame_err_d = 1'b1;
                end
            endcase
        end else if (state_q != IDLE) begin
            if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d     = IDLE;
                tcnt_d      = '0;
                frame_err_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end else begin
            tcnt_d = '0;
        end
    end

    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        keycode_d = keycode_q;
`ifdef PS2_MULTIKEY_EN
        older_d   = older_q;
`endif
        hid_code  = hid_map(byte_q);
        if (byte_done_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!ext_q && hid_code != '0) begin
                    if (!brk_q) begin
`ifdef PS2_MULTIKEY_EN
                        // A key already on the stack is a repeat and does not push.
                        if (hid_code != keycode_q && hid_code != older_q) begin
                            older_d   = keycode_q;
                            keycode_d = hid_code;
                        end
`else
                        keycode_d = hid_code;
`endif
                    end else if (hid_code == keycode_q) begin
`ifdef PS2_MULTIKEY_EN
                        keycode_d = older_q;
                        older_d   = '0;
`else
                        keycode_d = '0;
`endif
                    end
`ifdef PS2_MULTIKEY_EN
                    else if (hid_code == older_q) begin
                        older_d = '0;
                    end
`endif
                end
            end
        end
        key_valid_d = (keycode_d != keycode_q);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tcnt_q      <= '0;
            byte_done_q <= 1'b0;
            byte_q      <= '0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            keycode_q   <= '0;
            key_valid_q <= 1'b0;
`ifdef PS2_MULTIKEY_EN
            older_q     <= '0;
`endif
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tcnt_q      <= tcnt_d;
            byte_done_q <= byte_done_d;
            byte_q      <= shift_q;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            keycode_q   <= keycode_d;
            key_valid_q <= key_valid_d;
`ifdef PS2_MULTIKEY_EN
            older_q     <= older_d;
`endif
        end
    end

    assign keycode   = keycode_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;

endmodule
